complement_pair_checker: RTL and testbench

- Downstream stage of the generic N-bit worker.
- Consumes its registered data output and its inverted-data output. Checks every pair for bitwise complement consistency and buffers DEPTH samples (one worker WORKING burst).
- Reports error count and XOR checksum, then drains the buffered samples over a valid/ready stream to the next consumer (scoreboard/logger).

---
 rtl/complement_pair_checker_pkg.sv | 16 +
 rtl/complement_pair_checker_if.sv | 15 +
 rtl/complement_pair_checker_frame_buffer.sv | 24 ++
 rtl/complement_pair_checker.sv | 122 ++++++++++++
 tb/tb_complement_pair_checker.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/complement_pair_checker_pkg.sv
// Shared state encoding and constants for the complement pair checker.
package complement_pair_checker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    REPORT  = 2'b10,
    DRAIN   = 2'b11
  } state_t;

  // Low n bits set; the 64-bit shift wraps cleanly to all-ones at n == 64.
  function automatic logic [63:0] all_ones(input int unsigned n);
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/complement_pair_checker_if.sv
// Sample input and drain stream of the complement pair checker.
interface complement_pair_checker_if #(parameter int N = 4);
  logic         in_valid;
  logic [N-1:0] din;
  logic [N-1:0] din_inv;
  logic         out_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_last;

  modport master (output in_valid, din, din_inv, out_ready,
                  input  out_valid, out_data, out_last);
  modport slave  (input  in_valid, din, din_inv, out_ready,
                  output out_valid, out_data, out_last);
endinterface

// File: rtl/complement_pair_checker_frame_buffer.sv
// DEPTH x N sample store: one synchronous write port, one asynchronous read port.
module complement_pair_checker_frame_buffer #(
  parameter  int N     = 4,
  parameter  int DEPTH = 10,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [CW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [CW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/complement_pair_checker.sv
// Checks din/din_inv complement pairs over one DEPTH-sample frame, reports
// error count and XOR checksum, then drains the frame over valid/ready.
module complement_pair_checker
  import complement_pair_checker_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int DEPTH = 10,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  complement_pair_checker_if.slave bus,
  output logic [CW-1:0] err_count,
  output logic [N-1:0]  checksum,
  output logic          done,
  output logic          overflow,
  output logic          busy
);

  localparam logic [63:0]   ONES_W   = all_ones(N);
  localparam logic [N-1:0]  ALL_ONES = ONES_W[N-1:0];
  localparam logic [CW-1:0] LAST     = CW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] wr_ptr, wr_ptr_nxt;
  logic [CW-1:0] rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] err_nxt;
  logic [N-1:0]  cs_nxt;
  logic          ovf_nxt;
  logic          we;
  logic [CW-1:0] waddr;
  logic [N-1:0]  rdata;
  logic          pair_err;

  assign pair_err = (bus.din ^ bus.din_inv) != ALL_ONES;

  complement_pair_checker_frame_buffer #(.N(N), .DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      err_count <= '0;
      checksum  <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      err_count <= err_nxt;
      checksum  <= cs_nxt;
      overflow  <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    err_nxt    = err_count;
    cs_nxt     = checksum;
    ovf_nxt    = overflow;
    we         = 1'b0;
    waddr      = wr_ptr;
    case (state)
      IDLE: begin
        // First sample of a frame reloads all per-frame statistics.
        if (bus.in_valid) begin
          we         = 1'b1;
          waddr      = '0;
          wr_ptr_nxt = CW'(1);
          err_nxt    = CW'(pair_err);
          cs_nxt     = bus.din;
          ovf_nxt    = 1'b0;
          state_nxt  = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.in_valid) begin
          we         = 1'b1;
          wr_ptr_nxt = wr_ptr + CW'(1);
          err_nxt    = err_count + CW'(pair_err);
          cs_nxt     = checksum ^ bus.din;
          if (wr_ptr == LAST) state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (bus.in_valid) ovf_nxt = 1'b1;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        // A sample landing on the final transfer is still dropped.
        if (bus.in_valid) ovf_nxt = 1'b1;
        if (bus.out_ready) begin
          if (rd_ptr == LAST) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            state_nxt  = IDLE;
          end else begin
            rd_ptr_nxt = rd_ptr + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.out_valid = (state == DRAIN);
  assign bus.out_data  = bus.out_valid ? rdata : '0;
  assign bus.out_last  = bus.out_valid && (rd_ptr == LAST);
  assign done          = (state == REPORT);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_complement_pair_checker.sv
// Randomized and directed bench for complement_pair_checker with a frame-level model.
module tb_complement_pair_checker;

  localparam int N     = 4;
  localparam int DEPTH = 10;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [N-1:0] frame_t [DEPTH];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] err_count;
  logic [N-1:0]  checksum;
  logic          done, overflow, busy;

  complement_pair_checker_if #(.N(N)) bus ();

  complement_pair_checker #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count),
    .checksum  (checksum),
    .done      (done),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  frame_t       fd, fi;
  bit           de, dk, vk, dk1, vk1;
  logic [N-1:0] got_d [$];
  bit           got_l [$];
  int           stall_viol;
  bit           drain_to;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: a pair is bad unless din ^ din_inv is all ones.
  function automatic int exp_err(input frame_t d, input frame_t inv);
    int n = 0;
    for (int i = 0; i < DEPTH; i++)
      if ((d[i] ^ inv[i]) != {N{1'b1}}) n++;
    return n;
  endfunction

  function automatic logic [N-1:0] exp_cs(input frame_t d);
    logic [N-1:0] x = '0;
    for (int i = 0; i < DEPTH; i++) x = x ^ d[i];
    return x;
  endfunction

  function automatic int drain_mismatches(input frame_t d);
    int n = 0;
    if (got_d.size() != DEPTH || got_l.size() != DEPTH) return DEPTH + 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (got_d[i] !== d[i]) n++;
      if (got_l[i] !== (i == DEPTH - 1)) n++;
    end
    return n;
  endfunction

  // gap_mode: 0 contiguous, 1 alternating idle cycles, 2 random idle cycles.
  task automatic drive_frame(input int gap_mode, input bit inject);
    de = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
        bus.in_valid = 1'b0; bus.din = N'($urandom); bus.din_inv = N'($urandom);
        tick;
        if (done) de = 1'b1;
      end
      bus.in_valid = 1'b1; bus.din = fd[i]; bus.din_inv = fi[i];
      tick;
      if (i < DEPTH - 1 && done) de = 1'b1;
    end
    dk = done; vk = bus.out_valid;
    bus.in_valid = inject; bus.din = '1; bus.din_inv = '1;
    tick;
    dk1 = done; vk1 = bus.out_valid;
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  task automatic drain_frame(input int ready_mode, input bit inject);
    logic [N-1:0] held = '0, cur;
    bit held_v = 1'b0, r, last;
    got_d = {}; got_l = {}; stall_viol = 0; drain_to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (!bus.out_valid) begin drain_to = 1'b0; break; end
      if (held_v && bus.out_data !== held) stall_viol++;
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = (c % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      cur = bus.out_data; last = bus.out_last;
      bus.out_ready = r; bus.in_valid = inject; bus.din = '1; bus.din_inv = '1;
      tick;
      if (r) begin got_d.push_back(cur); got_l.push_back(last); held_v = 1'b0; end
      else begin held_v = 1'b1; held = cur; end
      if (r && last) begin bus.in_valid = 1'b0; bus.out_ready = 1'b0; end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.din = '0; bus.din_inv = '0;
    repeat (3) tick;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, err_count, checksum, done, overflow, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0",
               {bus.out_valid, bus.out_data, bus.out_last, err_count, checksum, done, overflow, busy});
    end
    rst = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle busy=%b valid=%b required 0,0", busy, bus.out_valid);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < DEPTH; i++) begin fd[i] = N'(i); fi[i] = ~N'(i); end
    drive_frame(0, 1'b0);
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL basic_early_done got %b required 0", de); end
    checks++; if ({dk, vk} !== 2'b10) begin errors++; $display("FAIL basic_done_edge_k got %b required 10", {dk, vk}); end
    checks++; if ({dk1, vk1} !== 2'b01) begin errors++; $display("FAIL basic_valid_edge_k1 got %b required 01", {dk1, vk1}); end
    checks++; if (err_count !== CW'(0)) begin errors++; $display("FAIL basic_err got %0d required 0", err_count); end
    checks++; if (checksum !== 4'h1) begin errors++; $display("FAIL basic_checksum got %h required 1", checksum); end
    drain_frame(0, 1'b0);
    checks++; if (drain_to) begin errors++; $display("FAIL basic_drain_timeout got timeout required completion"); end
    checks++; if (drain_mismatches(fd) != 0) begin errors++; $display("FAIL basic_drain got %0d mismatches required 0", drain_mismatches(fd)); end
    checks++; if ({busy, overflow} !== 2'b00) begin errors++; $display("FAIL basic_idle got busy,ovf=%b required 00", {busy, overflow}); end
    checks++; if (err_count !== CW'(0) || checksum !== 4'h1) begin errors++; $display("FAIL basic_hold got err=%0d cs=%h required 0,1", err_count, checksum); end
  endtask

  task automatic test_errors;
    for (int i = 0; i < DEPTH; i++) begin fd[i] = N'(i); fi[i] = (i == 3 || i == 7) ? N'(i) : ~N'(i); end
    drive_frame(0, 1'b0);
    checks++; if (err_count !== CW'(2)) begin errors++; $display("FAIL errors_count got %0d required 2", err_count); end
    checks++; if (checksum !== exp_cs(fd)) begin errors++; $display("FAIL errors_checksum got %h required %h", checksum, exp_cs(fd)); end
    drain_frame(0, 1'b0);
    checks++; if (drain_mismatches(fd) != 0 || drain_to) begin errors++; $display("FAIL errors_drain got %0d mismatches required 0", drain_mismatches(fd)); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < DEPTH; i++) begin fd[i] = N'($urandom); fi[i] = ~fd[i]; end
    drive_frame(0, 1'b0);
    drain_frame(1, 1'b0);
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes required 0", stall_viol); end
    checks++; if (got_d.size() != DEPTH || drain_to) begin errors++; $display("FAIL bp_count got %0d required %0d", got_d.size(), DEPTH); end
    checks++; if (drain_mismatches(fd) != 0) begin errors++; $display("FAIL bp_data got %0d mismatches required 0", drain_mismatches(fd)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got busy=%b required 0", busy); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < DEPTH; i++) begin fd[i] = N'($urandom); fi[i] = ~fd[i]; end
    drive_frame(0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_report got %b required 1", overflow); end
    drain_frame(0, 1'b1);
    checks++; if (drain_mismatches(fd) != 0 || drain_to) begin errors++; $display("FAIL ovf_drain got %0d mismatches required 0", drain_mismatches(fd)); end
    checks++; if ({overflow, busy} !== 2'b10) begin errors++; $display("FAIL ovf_sticky_idle got ovf,busy=%b required 10", {overflow, busy}); end
    bus.in_valid = 1'b1; bus.din = 4'h3; bus.din_inv = 4'h3;
    tick;
    bus.in_valid = 1'b0;
    checks++;
    if ({overflow, busy, err_count, checksum} !== {1'b0, 1'b1, CW'(1), 4'h3}) begin
      errors++; $display("FAIL ovf_new_frame got ovf=%b busy=%b err=%0d cs=%h required 0,1,1,3", overflow, busy, err_count, checksum);
    end
  endtask

  task automatic test_reset_midframe;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.din = N'($urandom); bus.din_inv = N'($urandom);
      tick;
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, err_count, checksum, done, overflow, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %h required 0",
               {bus.out_valid, bus.out_data, bus.out_last, err_count, checksum, done, overflow, busy});
    end
    tick;
    rst = 1'b1;
    tick;
    for (int i = 0; i < DEPTH; i++) begin fd[i] = 4'hA; fi[i] = 4'h5; end
    drive_frame(0, 1'b0);
    checks++; if (err_count !== CW'(0) || checksum !== 4'h0) begin errors++; $display("FAIL midreset_frame got err=%0d cs=%h required 0,0", err_count, checksum); end
    drain_frame(0, 1'b0);
    checks++; if (drain_mismatches(fd) != 0 || drain_to) begin errors++; $display("FAIL midreset_drain got %0d mismatches required 0", drain_mismatches(fd)); end
  endtask

  task automatic test_gaps;
    for (int i = 0; i < DEPTH; i++) begin fd[i] = N'(i); fi[i] = ~N'(i); end
    drive_frame(1, 1'b0);
    checks++; if ({de, dk, vk, dk1, vk1} !== 5'b01001) begin errors++; $display("FAIL gaps_timing got %b required 01001", {de, dk, vk, dk1, vk1}); end
    checks++; if (err_count !== CW'(0) || checksum !== 4'h1) begin errors++; $display("FAIL gaps_stats got err=%0d cs=%h required 0,1", err_count, checksum); end
    drain_frame(0, 1'b0);
    checks++; if (drain_mismatches(fd) != 0 || drain_to) begin errors++; $display("FAIL gaps_drain got %0d mismatches required 0", drain_mismatches(fd)); end
  endtask

  task automatic test_random;
    bit inj;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        fd[i] = N'($urandom);
        fi[i] = ($urandom_range(0, 3) == 0) ? N'($urandom) : ~fd[i];
      end
      inj = 1'($urandom_range(0, 1));
      drive_frame(2, inj);
      checks++;
      if ({de, dk, vk, dk1, vk1} !== 5'b01001) begin errors++; $display("FAIL rand%0d_timing got %b required 01001", f, {de, dk, vk, dk1, vk1}); end
      checks++;
      if (err_count !== CW'(exp_err(fd, fi)) || checksum !== exp_cs(fd)) begin
        errors++; $display("FAIL rand%0d_stats got err=%0d cs=%h required %0d,%h", f, err_count, checksum, exp_err(fd, fi), exp_cs(fd));
      end
      drain_frame(2, inj);
      checks++;
      if (drain_mismatches(fd) != 0 || drain_to || stall_viol != 0) begin
        errors++; $display("FAIL rand%0d_drain got %0d mismatches %0d stalls required 0,0", f, drain_mismatches(fd), stall_viol);
      end
      checks++;
      if (overflow !== inj || busy !== 1'b0) begin errors++; $display("FAIL rand%0d_ovf got ovf=%b busy=%b required %b,0", f, overflow, busy, inj); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.din = '0; bus.din_inv = '0; bus.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_errors;
    test_backpressure;
    test_overflow;
    test_reset_midframe;
    test_gaps;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
